imm_gen_pipe: RTL and testbench

Parametrised, registered immediate generator sitting between fetch and the decode/ID-EX register of the five-stage core.
- Accepts one 32-bit instruction per cycle via valid/ready and extracts the sign- or zero-extended immediate at XLEN width.
- Classifies the immediate format and forwards a sideband tag (e.g. PC).
- Buffers up to two results so that back-pressure from decode never drops an instruction.
- Adds to the existing combinational generator: AUIPC, JALR, RV64 OP-IMM-32, XLEN generalisation, a handshake and flush.

---
 rtl/imm_pkg.sv | 25 ++
 rtl/imm_extract.sv | 86 ++++++++
 rtl/imm_gen_pipe.sv | 136 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the registered immediate generator.
// Optional illegal-encoding check is enabled with IMM_ILLEGAL_CHK_EN.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I     = 3'd1,
      FMT_SHAMT = 3'd2,
      FMT_S     = 3'd3,
      FMT_B     = 3'd4,
      FMT_U     = 3'd5,
      FMT_J     = 3'd6
   } imm_fmt_t;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;

endpackage

// File: rtl/imm_extract.sv
// Combinational instruction -> {imm, fmt} decoder at XLEN width.
// IMM_ILLEGAL_CHK_EN adds the illegal-encoding flag output.
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output imm_fmt_t        fmt
`ifdef IMM_ILLEGAL_CHK_EN
   ,
   output logic            illegal
`endif
);

   logic [6:0] opc;
   logic [2:0] funct3;
   logic       wide_shamt;

   assign opc        = instr[6:0];
   assign funct3     = instr[14:12];
   // Only RV64 OP-IMM shifts carry a 6-bit shamt; the W forms stay at 5 bits.
   assign wide_shamt = (XLEN == 64) && (opc == OPC_OP_IMM);

   always_comb begin
      imm = '0;
      fmt = FMT_NONE;
      case (opc)
         OPC_LOAD, OPC_JALR: begin
            fmt = FMT_I;
            imm = XLEN'($signed(instr[31:20]));
         end
         OPC_OP_IMM, OPC_OP_IMM_32: begin
            if (opc == OPC_OP_IMM || XLEN == 64) begin
               if (funct3[1:0] == 2'b01) begin
                  fmt = FMT_SHAMT;
                  imm = XLEN'({wide_shamt & instr[25], instr[24:20]});
               end else begin
                  fmt = FMT_I;
                  imm = XLEN'($signed(instr[31:20]));
               end
            end
         end
         OPC_STORE: begin
            fmt = FMT_S;
            imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         end
         OPC_BRANCH: begin
            fmt = FMT_B;
            imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt = FMT_U;
            imm = XLEN'($signed({instr[31:12], 12'b0}));
         end
         OPC_JAL: begin
            fmt = FMT_J;
            imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         end
         default: begin
            fmt = FMT_NONE;
            imm = '0;
         end
      endcase
   end

`ifdef IMM_ILLEGAL_CHK_EN
   logic [6:0] shift_hi;

   always_comb begin
      // On RV32 instr[25] sits inside funct7, so a set bit already fails the compare.
      shift_hi = wide_shamt ? {instr[31:26], 1'b0} : instr[31:25];
      illegal  = (fmt == FMT_NONE);
      if (fmt == FMT_SHAMT) begin
         if (funct3[2] == 1'b0) begin
            illegal = (shift_hi != 7'b0000000);
         end else begin
            illegal = (shift_hi != 7'b0000000) && (shift_hi != 7'b0100000);
         end
      end
   end
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry valid/ready FIFO and flush.
// IMM_ILLEGAL_CHK_EN adds out_illegal carried with each entry.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [TAG_W-1:0] out_tag
`ifdef IMM_ILLEGAL_CHK_EN
   ,
   output logic             out_illegal
`endif
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      imm_fmt_t         fmt;
      logic [TAG_W-1:0] tag;
`ifdef IMM_ILLEGAL_CHK_EN
      logic             illegal;
`endif
   } imm_entry_t;

   logic [XLEN-1:0] ext_imm;
   imm_fmt_t        ext_fmt;
   imm_entry_t      new_entry;
   imm_entry_t      slot_reg [2];
   imm_entry_t      head_reg, head_next;
   logic [1:0]      count_reg, count_next;
   logic            rd_ptr_reg, rd_ptr_next;
   logic            wr_ptr_reg, wr_ptr_next;
   logic [1:0]      slot_we;
   logic            push, pop;

`ifdef IMM_ILLEGAL_CHK_EN
   logic ext_illegal;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr   (in_instr),
      .imm     (ext_imm),
      .fmt     (ext_fmt),
      .illegal (ext_illegal)
   );

   always_comb begin
      new_entry         = '0;
      new_entry.imm     = ext_imm;
      new_entry.fmt     = ext_fmt;
      new_entry.tag     = in_tag;
      new_entry.illegal = ext_illegal;
   end

   assign out_illegal = head_reg.illegal;
`else
   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr (in_instr),
      .imm   (ext_imm),
      .fmt   (ext_fmt)
   );

   always_comb begin
      new_entry     = '0;
      new_entry.imm = ext_imm;
      new_entry.fmt = ext_fmt;
      new_entry.tag = in_tag;
   end
`endif

   assign in_ready  = (count_reg < 2'd2);
   assign out_valid = (count_reg != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot_we
         assign slot_we[gi] = push & ~flush & (wr_ptr_reg == 1'(gi));
      end
   endgenerate

   // The head register preloads whatever entry will sit at rd_ptr next cycle,
   // so outputs come straight from a flop and hold their value when empty.
   always_comb begin
      count_next  = count_reg;
      rd_ptr_next = rd_ptr_reg;
      wr_ptr_next = wr_ptr_reg;
      head_next   = head_reg;
      if (flush) begin
         count_next  = 2'd0;
         rd_ptr_next = 1'b0;
         wr_ptr_next = 1'b0;
      end else begin
         if (push) wr_ptr_next = ~wr_ptr_reg;
         if (pop)  rd_ptr_next = ~rd_ptr_reg;
         count_next = count_reg + 2'(push) - 2'(pop);
         if (count_next != 2'd0) begin
            head_next = slot_we[rd_ptr_next] ? new_entry : slot_reg[rd_ptr_next];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg  <= 2'd0;
         rd_ptr_reg <= 1'b0;
         wr_ptr_reg <= 1'b0;
         head_reg   <= '0;
         for (int i = 0; i < 2; i++) slot_reg[i] <= '0;
      end else begin
         count_reg  <= count_next;
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         head_reg   <= head_next;
         for (int i = 0; i < 2; i++) begin
            if (slot_we[i]) slot_reg[i] <= new_entry;
         end
      end
   end

   assign out_imm = head_reg.imm;
   assign out_fmt = head_reg.fmt;
   assign out_tag = head_reg.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
// Builds with or without IMM_ILLEGAL_CHK_EN.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        reset, in_valid, flush, out_ready;
   logic [31:0] in_instr, in_tag;
   logic        rdy32, rdy64, v32, v64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   logic [2:0]  fmt32, fmt64;
   logic [31:0] tag32, tag64;
   logic        ill32, ill64;

   always #5 clk = ~clk;

`ifdef IMM_ILLEGAL_CHK_EN
   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
      .in_instr(in_instr), .in_tag(in_tag), .flush(flush), .out_valid(v32),
      .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32), .out_tag(tag32),
      .out_illegal(ill32));
   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
      .in_instr(in_instr), .in_tag(in_tag), .flush(flush), .out_valid(v64),
      .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64), .out_tag(tag64),
      .out_illegal(ill64));
`else
   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
      .in_instr(in_instr), .in_tag(in_tag), .flush(flush), .out_valid(v32),
      .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32), .out_tag(tag32));
   imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
      .in_instr(in_instr), .in_tag(in_tag), .flush(flush), .out_valid(v64),
      .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64), .out_tag(tag64));
   assign ill32 = 1'b0;
   assign ill64 = 1'b0;
`endif

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic [31:0] tag;
      logic        ill;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm32;
      logic [63:0] imm64;
      logic [2:0]  fmt32;
      logic [2:0]  fmt64;
      logic        ill32;
      logic        ill64;
   } vec_t;

   exp_t q32[$];
   exp_t q64[$];
   vec_t tab[13];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference decoder: immediates built as signed integers, then truncated to XLEN.
   function automatic exp_t ref_model(logic [31:0] ins, bit is64, logic [31:0] tag);
      exp_t       e;
      longint     v;
      int         f;
      bit         known;
      bit         shift;
      logic [6:0] op;
      logic [2:0] f3;
      v = 0; f = 0; known = 1; shift = 0;
      op = ins[6:0];
      f3 = ins[14:12];
      case (op)
         7'b0000011, 7'b1100111: begin f = 1; v = $signed(ins[31:20]); end
         7'b0010011, 7'b0011011: begin
            if (op == 7'b0010011 || is64) begin
               if (f3 == 3'd1 || f3 == 3'd5) begin
                  f = 2; shift = 1;
                  v = (is64 && op == 7'b0010011) ? ins[25:20] : ins[24:20];
               end else begin
                  f = 1; v = $signed(ins[31:20]);
               end
            end else known = 0;
         end
         7'b0100011: begin f = 3; v = $signed({ins[31:25], ins[11:7]}); end
         7'b1100011: begin f = 4; v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); end
         7'b0110111, 7'b0010111: begin f = 5; v = $signed(ins[31:12]) * 4096; end
         7'b1101111: begin f = 6; v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); end
         default: known = 0;
      endcase
      e.imm = is64 ? 64'(v) : (64'(v) & 64'h0000_0000_FFFF_FFFF);
      e.fmt = 3'(f);
      e.tag = tag;
      e.ill = !known;
      if (shift) begin
         if (is64 && op == 7'b0010011)
            e.ill = (f3 == 3'd1) ? (ins[31:26] != 6'h00) : !(ins[31:26] == 6'h00 || ins[31:26] == 6'h10);
         else
            e.ill = (f3 == 3'd1) ? (ins[31:25] != 7'h00) : !(ins[31:25] == 7'h00 || ins[31:25] == 7'h20);
      end
      return e;
   endfunction

   task automatic check_outputs();
      chk("x32 in_ready", rdy32, q32.size() < 2);
      chk("x64 in_ready", rdy64, q64.size() < 2);
      chk("x32 out_valid", v32, q32.size() != 0);
      chk("x64 out_valid", v64, q64.size() != 0);
      if (q32.size() != 0) begin
         chk("x32 out_imm", imm32, q32[0].imm);
         chk("x32 out_fmt", fmt32, q32[0].fmt);
         chk("x32 out_tag", tag32, q32[0].tag);
`ifdef IMM_ILLEGAL_CHK_EN
         chk("x32 out_illegal", ill32, q32[0].ill);
`endif
      end
      if (q64.size() != 0) begin
         chk("x64 out_imm", imm64, q64[0].imm);
         chk("x64 out_fmt", fmt64, q64[0].fmt);
         chk("x64 out_tag", tag64, q64[0].tag);
`ifdef IMM_ILLEGAL_CHK_EN
         chk("x64 out_illegal", ill64, q64[0].ill);
`endif
      end
   endtask

   task automatic model_update();
      bit do_push;
      bit do_pop;
      do_push = in_valid && (q32.size() < 2);
      do_pop  = (q32.size() != 0) && out_ready;
      if (reset || flush) begin
         q32.delete();
         q64.delete();
      end else begin
         if (do_pop) begin
            $display("[TB] pop  tag=%h imm32=%h fmt32=%0d imm64=%h fmt64=%0d",
                     q32[0].tag, q32[0].imm[31:0], q32[0].fmt, q64[0].imm, q64[0].fmt);
            void'(q32.pop_front());
            void'(q64.pop_front());
         end
         if (do_push) begin
            q32.push_back(ref_model(in_instr, 1'b0, in_tag));
            q64.push_back(ref_model(in_instr, 1'b1, in_tag));
         end
      end
   endtask

   // One clock: check at the falling edge, advance the model on the rising edge.
   task automatic step();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(logic [31:0] ins, logic [31:0] tag);
      in_valid = 1'b1;
      in_instr = ins;
      in_tag   = tag;
   endtask

   logic [6:0]  opcs [11];
   logic [31:0] r;

   initial begin
      tab[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0};
      tab[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 3'd3, 1'b0, 1'b0};
      tab[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd4, 3'd4, 1'b0, 1'b0};
      tab[3]  = '{32'h4030D093, 32'h00000003, 64'h0000000000000003, 3'd2, 3'd2, 1'b0, 1'b0};
      tab[4]  = '{32'hFFFFF0B7, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 3'd5, 3'd5, 1'b0, 1'b0};
      tab[5]  = '{32'h02009093, 32'h00000000, 64'h0000000000000020, 3'd2, 3'd2, 1'b1, 1'b0};
      tab[6]  = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd0, 3'd0, 1'b1, 1'b1};
      tab[7]  = '{32'h0010909B, 32'h00000000, 64'h0000000000000001, 3'd0, 3'd2, 1'b1, 1'b0};
      tab[8]  = '{32'hFFF0809B, 32'h00000000, 64'hFFFFFFFFFFFFFFFF, 3'd0, 3'd1, 1'b1, 1'b0};
      tab[9]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd6, 3'd6, 1'b0, 1'b0};
      tab[10] = '{32'h00001097, 32'h00001000, 64'h0000000000001000, 3'd5, 3'd5, 1'b0, 1'b0};
      tab[11] = '{32'h7FF02083, 32'h000007FF, 64'h00000000000007FF, 3'd1, 3'd1, 1'b0, 1'b0};
      tab[12] = '{32'h2000D093, 32'h00000000, 64'h0000000000000000, 3'd2, 3'd2, 1'b1, 1'b1};
      opcs = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h33};

      reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; flush = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset x32 out_valid", v32, 1'b0);
      chk("reset x32 out_imm", imm32, 0);
      chk("reset x32 out_fmt", fmt32, 3'd0);
      chk("reset x32 out_tag", tag32, 0);
      chk("reset x64 out_valid", v64, 1'b0);
      chk("reset x64 out_imm", imm64, 0);
      chk("reset x64 out_fmt", fmt64, 3'd0);
      chk("reset x64 out_tag", tag64, 0);
      chk("reset x32 out_illegal", ill32, 1'b0);
      reset = 1'b0;
      #1;
      chk("post-reset in_ready", rdy32, 1'b1);

      // Back-to-back table vectors, each visible the cycle after it is pushed.
      for (int i = 0; i < 13; i++) begin
         drive(tab[i].instr, 32'h100 + i);
         step();
         $display("[TB] vec %0d instr=%h imm32=%h imm64=%h", i, tab[i].instr, imm32, imm64);
         chk("tab x32 out_valid", v32, 1'b1);
         chk("tab x32 out_imm", imm32, tab[i].imm32);
         chk("tab x32 out_fmt", fmt32, tab[i].fmt32);
         chk("tab x32 out_tag", tag32, 32'h100 + i);
         chk("tab x64 out_imm", imm64, tab[i].imm64);
         chk("tab x64 out_fmt", fmt64, tab[i].fmt64);
`ifdef IMM_ILLEGAL_CHK_EN
         chk("tab x32 out_illegal", ill32, tab[i].ill32);
         chk("tab x64 out_illegal", ill64, tab[i].ill64);
`endif
      end
      in_valid = 1'b0;
      step();

      // Back-pressure: third instruction waits for space, order preserved.
      out_ready = 1'b0;
      drive(32'hFFF00093, 32'h1); step();
      drive(32'hFE112E23, 32'h2); step();
      drive(32'hFE000CE3, 32'h3); step();
      chk("full in_ready", rdy32, 1'b0);
      chk("full head tag", tag32, 32'h1);
      step();
      chk("full hold tag", tag32, 32'h1);
      chk("full hold imm", imm32, 32'hFFFFFFFF);
      out_ready = 1'b1;
      step();
      chk("drain 1 tag", tag32, 32'h2);
      step();
      chk("drain 2 tag", tag32, 32'h3);
      in_valid = 1'b0;
      step();
      chk("drain empty", v32, 1'b0);

      // Flush while full, with a new instruction presented.
      out_ready = 1'b0;
      drive(32'h00001097, 32'h11); step();
      drive(32'h7FF02083, 32'h12); step();
      drive(32'hFFDFF06F, 32'h13); flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush out_valid", v32, 1'b0);
      chk("flush in_ready", rdy32, 1'b1);
      chk("flush x64 out_valid", v64, 1'b0);
      out_ready = 1'b1;
      drive(32'hFFFFF0B7, 32'h14); step();
      chk("after flush tag", tag32, 32'h14);
      in_valid = 1'b0;
      step();

      // Reset in the middle of traffic clears outputs too.
      out_ready = 1'b0;
      drive(32'hFE112E23, 32'h21); step();
      drive(32'hFE000CE3, 32'h22); reset = 1'b1; step();
      reset = 1'b0; in_valid = 1'b0;
      chk("mid reset out_valid", v32, 1'b0);
      chk("mid reset out_imm", imm64, 0);
      chk("mid reset out_tag", tag32, 0);
      chk("mid reset out_fmt", fmt32, 3'd0);
      out_ready = 1'b1;
      step();

      // Random traffic against the scoreboard; inputs held while stalled.
      for (int c = 0; c < 600; c++) begin
         if (!(in_valid && q32.size() == 2)) begin
            r        = $urandom();
            in_valid = ($urandom_range(0, 99) < 70);
            in_instr = {r[31:7], opcs[$urandom_range(0, 10)]};
            in_tag   = $urandom();
         end
         out_ready = ($urandom_range(0, 99) < 60);
         flush     = ($urandom_range(0, 99) < 3);
         step();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
